// File: rtl/router_fsm.sv
// router_fsm -- packet router write-side controller.
//
// Tracks a packet from its header byte through payload and parity into one of
// three FIFOs, stalls the source while a FIFO is busy or full, and returns to
// address decode on completion, on a timeout (soft reset) of the selected
// FIFO, or on reset.
//
// Optional feature macro: ROUTER_FSM_ADDR_CHECK_EN
//   defined   : a header with address 2'b11 moves to DROP_PACKET and
//               addr_err pulses for one cycle.
//   undefined : address 2'b11 just holds the FSM in DECODE_ADDRESS;
//               addr_err is tied low.
//
// Ports
//   clock                      rising-edge clock
//   reset                      asynchronous active-high reset
//   pkt_valid                  header/payload byte valid from source
//   data_in[1:0]               header address field (00/01/10 -> FIFO 0/1/2)
//   fifo_empty_0..2            per-FIFO empty flags
//   soft_reset_0..2            per-FIFO timeout resets
//   fifo_full                  full flag of the addressed FIFO
//   parity_done                parity byte has been written
//   low_pkt_valid              pkt_valid fell while the FIFO was full
//   detect_add, lfd_state,
//   ld_state, laf_state,
//   full_state                 state decodes
//   write_enb_reg              FIFO write request
//   rst_int_reg                parity-check strobe
//   busy                       source stall
//   addr_err                   one-cycle pulse on illegal-address drop
//
// All outputs are registered: they are decoded from the next state and loaded
// together with the state register, so they always reflect the current state
// and have no combinational path from any input.

module router_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       fifo_full,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       addr_err
);

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    FIFO_FULL_STATE    = 4'd3,
    LOAD_AFTER_FULL    = 4'd4,
    LOAD_PARITY        = 4'd5,
    CHECK_PARITY_ERROR = 4'd6,
    WAIT_TILL_EMPTY    = 4'd7
`ifdef ROUTER_FSM_ADDR_CHECK_EN
    ,
    DROP_PACKET        = 4'd8
`endif
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] addr_q;

  logic       hdr_empty;   // empty flag of the FIFO named by the incoming header
  logic       sel_empty;   // empty flag of the latched FIFO
  logic       sel_soft_rst;

  // Header address is not latched yet in DECODE_ADDRESS, so the empty check
  // there must look at data_in directly.
  always_comb begin
    hdr_empty = 1'b0;
    case (data_in)
      2'b00:   hdr_empty = fifo_empty_0;
      2'b01:   hdr_empty = fifo_empty_1;
      2'b10:   hdr_empty = fifo_empty_2;
      default: hdr_empty = 1'b0;
    endcase
  end

  always_comb begin
    sel_empty    = 1'b0;
    sel_soft_rst = 1'b0;
    case (addr_q)
      2'b00: begin
        sel_empty    = fifo_empty_0;
        sel_soft_rst = soft_reset_0;
      end
      2'b01: begin
        sel_empty    = fifo_empty_1;
        sel_soft_rst = soft_reset_1;
      end
      2'b10: begin
        sel_empty    = fifo_empty_2;
        sel_soft_rst = soft_reset_2;
      end
      default: begin
        sel_empty    = 1'b0;
        sel_soft_rst = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (sel_soft_rst) begin
      // Timeout of the FIFO being written abandons the packet from any state.
      state_nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (pkt_valid && data_in != 2'b11) begin
            state_nxt = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
`ifdef ROUTER_FSM_ADDR_CHECK_EN
          else if (pkt_valid && data_in == 2'b11) begin
            state_nxt = DROP_PACKET;
          end
`endif
        end
        LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       state_nxt = FIFO_FULL_STATE;
          else if (!pkt_valid) state_nxt = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) state_nxt = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_nxt = DECODE_ADDRESS;
          else if (low_pkt_valid) state_nxt = LOAD_PARITY;
          else                    state_nxt = LOAD_DATA;
        end
        LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          if (sel_empty) state_nxt = LOAD_FIRST_DATA;
        end
`ifdef ROUTER_FSM_ADDR_CHECK_EN
        DROP_PACKET: begin
          if (!pkt_valid) state_nxt = DECODE_ADDRESS;
        end
`endif
        default: state_nxt = DECODE_ADDRESS;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= DECODE_ADDRESS;
      addr_q        <= '0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      write_enb_reg <= 1'b0;
      rst_int_reg   <= 1'b0;
      busy          <= 1'b0;
`ifdef ROUTER_FSM_ADDR_CHECK_EN
      addr_err      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == DECODE_ADDRESS && pkt_valid) begin
        addr_q <= data_in;
      end
      detect_add    <= (state_nxt == DECODE_ADDRESS);
      lfd_state     <= (state_nxt == LOAD_FIRST_DATA);
      ld_state      <= (state_nxt == LOAD_DATA);
      laf_state     <= (state_nxt == LOAD_AFTER_FULL);
      full_state    <= (state_nxt == FIFO_FULL_STATE);
      write_enb_reg <= (state_nxt inside {LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY});
      rst_int_reg   <= (state_nxt == CHECK_PARITY_ERROR);
      busy          <= (state_nxt inside {LOAD_FIRST_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL,
                                          LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY});
`ifdef ROUTER_FSM_ADDR_CHECK_EN
      // Pulse only on the entry edge, not for the whole drop.
      addr_err      <= (state_nxt == DROP_PACKET) && (state != DROP_PACKET);
`endif
    end
  end

`ifndef ROUTER_FSM_ADDR_CHECK_EN
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm -- self-checking bench for router_fsm.
// Directed scenarios followed by randomized stimulus, every cycle compared
// against a behavioural model of the packet-level rules.
// Honours ROUTER_FSM_ADDR_CHECK_EN the same way the design does.

module tb_router_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       fifo_full, parity_done, low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy, addr_err;

  router_fsm dut (
    .clock        (clock),
    .reset        (reset),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_empty_0 (fifo_empty_0),
    .fifo_empty_1 (fifo_empty_1),
    .fifo_empty_2 (fifo_empty_2),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2),
    .fifo_full    (fifo_full),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .write_enb_reg(write_enb_reg),
    .rst_int_reg  (rst_int_reg),
    .busy         (busy),
    .addr_err     (addr_err)
  );

  always #5 clock = ~clock;

`ifdef ROUTER_FSM_ADDR_CHECK_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_DEC, M_LFD, M_LD, M_FULL, M_LAF, M_LP, M_CPE, M_WAIT, M_DROP} mstate_t;
  mstate_t ms;
  int      ma;     // latched FIFO address
  bit      merr;

  // Per-phase output table: {detect,lfd,ld,laf,full,we,rst_int,busy}
  function automatic logic [8:0] exp_out();
    logic [7:0] t;
    case (ms)
      M_DEC:   t = 8'b1000_0000;
      M_LFD:   t = 8'b0100_0001;
      M_LD:    t = 8'b0010_0100;
      M_FULL:  t = 8'b0000_1001;
      M_LAF:   t = 8'b0001_0101;
      M_LP:    t = 8'b0000_0101;
      M_CPE:   t = 8'b0000_0011;
      M_WAIT:  t = 8'b0000_0001;
      default: t = 8'b0000_0000;
    endcase
    return {t, merr};
  endfunction

  function automatic logic [8:0] obs_out();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            write_enb_reg, rst_int_reg, busy, addr_err};
  endfunction

  task automatic model_reset();
    ms = M_DEC; ma = 0; merr = 1'b0;
  endtask

  task automatic model_step();
    bit [2:0] emp;
    bit [2:0] srs;
    mstate_t  nx;
    int       din;
    if (reset) begin
      model_reset();
      return;
    end
    emp = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    srs = {soft_reset_2, soft_reset_1, soft_reset_0};
    din = int'(data_in);
    nx  = ms;
    if (ma < 3 && srs[ma]) nx = M_DEC;
    else begin
      case (ms)
        M_DEC:  if (pkt_valid && din != 3) nx = emp[din] ? M_LFD : M_WAIT;
                else if (pkt_valid && DROP_EN) nx = M_DROP;
        M_LFD:  nx = M_LD;
        M_LD:   nx = fifo_full ? M_FULL : (!pkt_valid ? M_LP : M_LD);
        M_FULL: nx = fifo_full ? M_FULL : M_LAF;
        M_LAF:  nx = parity_done ? M_DEC : (low_pkt_valid ? M_LP : M_LD);
        M_LP:   nx = M_CPE;
        M_CPE:  nx = fifo_full ? M_FULL : M_DEC;
        M_WAIT: nx = emp[ma] ? M_LFD : M_WAIT;
        M_DROP: nx = pkt_valid ? M_DROP : M_DEC;
        default: nx = M_DEC;
      endcase
    end
    merr = (nx == M_DROP) && (ms != M_DROP);
    if (ms == M_DEC && pkt_valid) ma = din;
    ms = nx;
  endtask

  // ---------------- per-cycle driver ----------------
  int n_we, n_ld, n_full, n_wait, n_err, m_we;

  task automatic clear_counts();
    n_we = 0; n_ld = 0; n_full = 0; n_wait = 0; n_err = 0; m_we = 0;
  endtask

  task automatic cycle();
    logic [8:0] e;
    @(posedge clock);
    model_step();
    #1;
    e = exp_out();
    check("outputs", 32'(obs_out()), 32'(e));
    if (ma == 3) check("no_write_addr11", 32'(write_enb_reg), 32'd0);
    n_we   += int'(write_enb_reg);
    m_we   += int'(e[3]);
    n_ld   += int'(ld_state);
    n_full += int'(full_state);
    n_err  += int'(addr_err);
    // WAIT_TILL_EMPTY is the only phase that shows busy alone
    if (obs_out() == 9'b0_0000_0010) n_wait++;
  endtask

  task automatic idle_inputs();
    pkt_valid = 1'b0; data_in = 2'b00;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    fifo_full = 1'b0; parity_done = 1'b0; low_pkt_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_outputs", 32'(obs_out()), 32'h100);
    cycle();
    reset = 1'b0;
    cycle();

    // Header addr 01, five LOAD_DATA cycles, parity, back to decode.
    clear_counts();
    pkt_valid = 1'b1; data_in = 2'b01;
    cycle();
    check("lfd_after_header", 32'(lfd_state), 32'd1);
    repeat (5) cycle();
    pkt_valid = 1'b0;
    cycle();
    check("load_parity_we", 32'(write_enb_reg), 32'd1);
    cycle();
    check("check_parity_strobe", 32'(rst_int_reg), 32'd1);
    cycle();
    check("pkt1_done", 32'(detect_add), 32'd1);
    check("pkt1_ld_cycles", 32'(n_ld), 32'd5);
    check("pkt1_write_cycles", 32'(n_we), 32'(m_we));

    // FIFO full for three sampled cycles during LOAD_DATA.
    clear_counts();
    pkt_valid = 1'b1; data_in = 2'b00;
    cycle(); cycle();
    fifo_full = 1'b1;
    repeat (3) cycle();
    check("full_busy", 32'(busy), 32'd1);
    check("full_no_write", 32'(write_enb_reg), 32'd0);
    fifo_full = 1'b0;
    cycle();
    check("laf_entered", 32'(laf_state), 32'd1);
    check("full_cycles", 32'(n_full), 32'd3);
    cycle();
    check("back_to_ld", 32'(ld_state), 32'd1);

    // Soft reset of another FIFO is ignored, of the selected FIFO aborts.
    fifo_full = 1'b1;
    cycle();
    soft_reset_1 = 1'b1;
    cycle();
    check("sr_other_ignored", 32'(full_state), 32'd1);
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    cycle();
    check("sr_selected_abort", 32'(detect_add), 32'd1);
    soft_reset_0 = 1'b0; fifo_full = 1'b0; pkt_valid = 1'b0;
    cycle();

    // Header addr 10 with FIFO 2 occupied for four cycles.
    clear_counts();
    pkt_valid = 1'b1; data_in = 2'b10; fifo_empty_2 = 1'b0;
    repeat (4) cycle();
    fifo_empty_2 = 1'b1;
    cycle();
    check("wait_cycles", 32'(n_wait), 32'd4);
    check("lfd_after_wait", 32'(lfd_state), 32'd1);
    pkt_valid = 1'b0;
    repeat (4) cycle();
    check("pkt3_done", 32'(detect_add), 32'd1);

    // Illegal address 11.
    clear_counts();
    pkt_valid = 1'b1; data_in = 2'b11;
    cycle();
    check("addr11_err_entry", 32'(addr_err), 32'(DROP_EN));
    cycle();
    check("addr11_err_single", 32'(addr_err), 32'd0);
    check("addr11_detect", 32'(detect_add), 32'(!DROP_EN));
    pkt_valid = 1'b0;
    cycle();
    check("addr11_writes", 32'(n_we), 32'd0);
    check("addr11_err_count", 32'(n_err), 32'(DROP_EN));
    check("addr11_done", 32'(detect_add), 32'd1);

    // Asynchronous reset in the middle of LOAD_DATA.
    pkt_valid = 1'b1; data_in = 2'b01;
    cycle(); cycle();
    check("in_ld_before_reset", 32'(ld_state), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_detect", 32'(detect_add), 32'd1);
    check("async_rst_we", 32'(write_enb_reg), 32'd0);
    cycle();
    reset = 1'b0; pkt_valid = 1'b0;
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      pkt_valid     = ($urandom_range(0, 9) < 7);
      data_in       = 2'($urandom_range(0, 3));
      fifo_empty_0  = ($urandom_range(0, 9) < 7);
      fifo_empty_1  = ($urandom_range(0, 9) < 7);
      fifo_empty_2  = ($urandom_range(0, 9) < 7);
      soft_reset_0  = ($urandom_range(0, 99) < 3);
      soft_reset_1  = ($urandom_range(0, 99) < 3);
      soft_reset_2  = ($urandom_range(0, 99) < 3);
      fifo_full     = ($urandom_range(0, 99) < 15);
      parity_done   = ($urandom_range(0, 9) < 3);
      low_pkt_valid = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        check("rand_async_rst", 32'(obs_out()), 32'h100);
      end
      cycle();
      reset = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
